if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
- Parametrised instruction-fetch unit with a PC generator, an instruction-cache lookup and a byte-serial memory refill engine.
- Fetched instructions go into a FIFO prefetch queue, which the decode stage drains through a valid/ready handshake.
- Improves on the single-buffer fetch: handles memory-arbiter stalls without losing bytes, flushes cleanly on redirect, and keeps fetching ahead.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INST_BYTES, 4, bytes per instruction, fetched little-endian; range 1..8.
- QUEUE_DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- redirect_i  in  1  branch/jump redirect, one-cycle pulse.
- redirect_addr_i  in  ADDR_W  redirect target.
- cache_raddr_o  out  ADDR_W  cache lookup address.
- cache_rreq_o  out  1  lookup strobe.
- cache_hit_i  in  1  hit, valid the cycle after cache_rreq_o.
- cache_inst_i  in  8*INST_BYTES  hit data, same cycle as cache_hit_i.
- cache_we_o  out  1  refill write pulse.
- cache_waddr_o  out  ADDR_W  refill address.
- cache_wdata_o  out  8*INST_BYTES  refill data.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  ADDR_W  byte address.
- mem_gnt_i  in  1  arbiter grant; request accepted when mem_req_o and mem_gnt_i are both high.
- mem_byte_i  in  8  read data, valid exactly one cycle after acceptance.
- inst_valid_o  out  1  queue head valid.
- inst_o  out  8*INST_BYTES  head instruction.
- inst_pc_o  out  ADDR_W  head PC.
- inst_ready_i  in  1  consumer pop.

Behaviour:
- Reset. Every output register goes low/zero. fetch_pc <= RESET_PC. Queue empty. State IDLE. No pending memory return.
- States:
  - IDLE. Moves to LOOKUP when the queue is not full and no redirect is present.
  - LOOKUP. cache_rreq_o=1 and cache_raddr_o=fetch_pc for exactly one cycle, then go to CHECK.
  - CHECK. On cache_hit_i: push {fetch_pc, cache_inst_i}, fetch_pc += INST_BYTES, go to IDLE. On miss: byte counter issue_cnt=0 and recv_cnt=0, go to REFILL.
  - REFILL. mem_req_o=1 and mem_addr_o=fetch_pc+issue_cnt while issue_cnt<INST_BYTES. issue_cnt increments only on acceptance; with no grant, address and request are held. A byte accepted in cycle N is captured from mem_byte_i in cycle N+1 into byte lane recv_cnt, then recv_cnt increments. This capture is independent of mem_gnt_i in cycle N+1. When recv_cnt reaches INST_BYTES, go to DONE.
  - DONE. One cycle. Pulse cache_we_o with cache_waddr_o=fetch_pc and cache_wdata_o=the assembled word. Push to the queue. fetch_pc += INST_BYTES. Go to IDLE.
- Latency.
  - Hit: redirect or idle to queue-visible is 3 cycles (LOOKUP, CHECK, then inst_valid_o high).
  - Miss with continuous grant: 2 + INST_BYTES + 2 cycles.
- Queue.
  - Push and pop are allowed in the same cycle.
  - A push is never attempted when the queue is full; IDLE gating guarantees this.
  - Pop occurs when inst_valid_o and inst_ready_i are both high.
  - Pointers wrap modulo QUEUE_DEPTH; a count register of width clog2(QUEUE_DEPTH)+1.
- Redirect has priority over every other event in that cycle.
  - Queue flushed and any pop ignored.
  - fetch_pc <= redirect_addr_i. State goes to LOOKUP on the next cycle, regardless of fullness, because the queue is now empty.
  - Any in-flight REFILL is aborted and mem_req_o drops the next cycle.
  - A byte accepted in the redirect cycle still returns; it is discarded via a one-cycle drop flag.
  - No cache write occurs for an aborted refill.
  - A redirect during DONE suppresses both the push and cache_we_o.
- Arithmetic. All address adds wrap modulo 2^ADDR_W.
- Reset mid-refill. State returns to reset values on the next edge. A pending return byte is ignored.
- cache_we_o and cache_rreq_o are never high in the same cycle.

Decomposition:
- Package if_pkg:
  - state enum {IDLE, LOOKUP, CHECK, REFILL, DONE};
  - INST_W = 8*INST_BYTES;
  - queue entry struct {pc, inst}.
- Sub-module if_fifo: parametrised synchronous FIFO with push, pop, flush, full, empty and count. It holds the prefetch queue.
- The FSM and refill datapath stay in the top module.

Test Plan:
- Hit stream, INST_BYTES=4, QUEUE_DEPTH=4, ready=1. Cache always hits at PC 0x0, 0x4, 0x8. Required: inst_pc_o sequence 0x0, 0x4, 0x8; first inst_valid_o 3 cycles after reset release; mem_req_o never high.
- Miss refill. Memory bytes at 0x10..0x13 are 0x13, 0x05, 0x10, 0x00. Required: inst_o=0x00100513 with inst_pc_o=0x10; single cache_we_o pulse with waddr 0x10 and wdata 0x00100513.
- Arbiter stall. mem_gnt_i low for 3 cycles after the second byte is accepted. Required: mem_addr_o held at base+2 throughout, assembled word identical to the no-stall case, no byte duplicated or skipped.
- Queue full. inst_ready_i=0 with all hits. Required: exactly 4 entries pushed, FSM parks in IDLE, no cache_rreq_o. Raise ready for one cycle: exactly one new lookup follows.
- Redirect mid-refill to 0x100, issued after 2 bytes are accepted. Required: no cache_we_o for the old PC, queue empty, next cache_raddr_o=0x100, the late returning byte not used.
- Redirect and pop in the same cycle with a full queue. Required: count becomes 0, no entry from the old stream is ever presented afterwards, first new inst_pc_o equals the redirect target.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch slice: FSM states and the default
// queue-entry layout.
package if_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CHECK  = 3'd2,
    REFILL = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_INST_BYTES = 4;
  localparam int INST_W         = 8 * DEF_INST_BYTES;

  // Entry layout for the default configuration; the top builds the same
  // shape from its own parameters.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [INST_W-1:0]     inst;
  } q_entry_t;

  function automatic int inst_width(input int nbytes);
    return 8 * nbytes;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Show-ahead synchronous FIFO holding fetched {pc, inst} entries; flush empties
// it in one cycle.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             wr, rd;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rptr_q];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign wr = push_i && !flush_i && (!full_o || pop_i);
  assign rd = pop_i && !flush_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + PW'(1);
      if (rd) rptr_q <= rptr_q + PW'(1);
      unique case ({wr, rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch: PC generator, cache lookup, byte-serial refill from memory,
// and a prefetch FIFO drained by decode.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                INST_BYTES  = DEF_INST_BYTES,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_addr_i,
  output logic [ADDR_W-1:0]            cache_raddr_o,
  output logic                         cache_rreq_o,
  input  logic                         cache_hit_i,
  input  logic [8*INST_BYTES-1:0]      cache_inst_i,
  output logic                         cache_we_o,
  output logic [ADDR_W-1:0]            cache_waddr_o,
  output logic [8*INST_BYTES-1:0]      cache_wdata_o,
  output logic                         mem_req_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic [7:0]                   mem_byte_i,
  output logic                         inst_valid_o,
  output logic [8*INST_BYTES-1:0]      inst_o,
  output logic [ADDR_W-1:0]            inst_pc_o,
  input  logic                         inst_ready_i
);

  localparam int                IW     = inst_width(INST_BYTES);
  localparam int                CNT_W  = $clog2(INST_BYTES + 1);
  localparam int                QCW    = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  NBYTES = CNT_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INST_BYTES);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [IW-1:0]     inst;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
  logic [IW-1:0]     word_q, word_d;
  logic              pend_q, drop_q;

  logic              accept, capture, push, we;
  logic              fifo_push, fifo_pop;
  logic              q_full, q_empty;
  logic [QCW-1:0]    q_count;
  entry_t            push_entry, head_entry;

  assign mem_req_o = (state_q == REFILL) && (issue_cnt_q < NBYTES);
  assign accept    = mem_req_o && mem_gnt_i;
  // pend/drop describe the byte accepted last cycle; a redirect in that cycle
  // marks it as stale.
  assign capture   = (state_q == REFILL) && pend_q && !drop_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    word_d      = word_q;
    push        = 1'b0;
    we          = 1'b0;
    if (redirect_i) begin
      fetch_pc_d = redirect_addr_i;
      state_d    = LOOKUP;
    end else begin
      unique case (state_q)
        IDLE:   if (q_count != QCW'(QUEUE_DEPTH)) state_d = LOOKUP;
        LOOKUP: state_d = CHECK;
        CHECK: begin
          if (cache_hit_i) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + STEP;
            state_d    = IDLE;
          end else begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            word_d      = '0;
            state_d     = REFILL;
          end
        end
        REFILL: begin
          if (accept) issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (capture) begin
            for (int b = 0; b < INST_BYTES; b++) begin
              if (recv_cnt_q == CNT_W'(b)) word_d[8*b +: 8] = mem_byte_i;
            end
            recv_cnt_d = recv_cnt_q + CNT_W'(1);
            if (recv_cnt_d == NBYTES) state_d = DONE;
          end
        end
        DONE: begin
          we         = 1'b1;
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + STEP;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      word_q      <= word_d;
      pend_q      <= accept;
      drop_q      <= accept && redirect_i;
    end
  end

  assign push_entry.pc   = fetch_pc_q;
  assign push_entry.inst = (state_q == DONE) ? word_q : cache_inst_i;
  assign fifo_pop        = inst_valid_o && inst_ready_i && !redirect_i;
  assign fifo_push       = push && (!q_full || fifo_pop);

  if_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_i),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_entry),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  assign cache_rreq_o  = (state_q == LOOKUP);
  assign cache_raddr_o = fetch_pc_q;
  assign cache_we_o    = we;
  assign cache_waddr_o = fetch_pc_q;
  assign cache_wdata_o = word_q;
  assign mem_addr_o    = fetch_pc_q + ADDR_W'(issue_cnt_q);
  assign inst_valid_o  = !q_empty;
  assign inst_o        = q_empty ? '0 : head_entry.inst;
  assign inst_pc_o     = q_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a small reactive cache/memory model.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic [31:0] cache_raddr_o;
  logic        cache_rreq_o;
  logic        cache_hit_i = 1'b0;
  logic [31:0] cache_inst_i = '0;
  logic        cache_we_o;
  logic [31:0] cache_waddr_o;
  logic [31:0] cache_wdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b1;
  logic [7:0]  mem_byte_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  int          n_assert = 0;
  int          n_fail = 0;
  bit          hit_en = 1'b0;
  int          rreq_cnt, we_cnt, mreq_cnt, acc_cnt, both_cnt, n;
  logic [31:0] last_we_addr, last_we_data;
  logic [31:0] pop_pc_q[$];

  if_prefetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .cache_raddr_o   (cache_raddr_o),
    .cache_rreq_o    (cache_rreq_o),
    .cache_hit_i     (cache_hit_i),
    .cache_inst_i    (cache_inst_i),
    .cache_we_o      (cache_we_o),
    .cache_waddr_o   (cache_waddr_o),
    .cache_wdata_o   (cache_wdata_o),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_byte_i      (mem_byte_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_ready_i    (inst_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_of(input logic [31:0] a);
    case (a)
      32'h10:  return 8'h13;
      32'h11:  return 8'h05;
      32'h12:  return 8'h10;
      32'h13:  return 8'h00;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] cache_of(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples requests before the edge, then answers them one cycle later.
  task automatic tick();
    logic        rq, acc;
    logic [31:0] ra, ma;
    #1;
    rq  = cache_rreq_o;
    ra  = cache_raddr_o;
    acc = mem_req_o && mem_gnt_i;
    ma  = mem_addr_o;
    if (rq) rreq_cnt++;
    if (mem_req_o) mreq_cnt++;
    if (acc) acc_cnt++;
    if (cache_we_o) begin
      we_cnt++;
      last_we_addr = cache_waddr_o;
      last_we_data = cache_wdata_o;
    end
    if (cache_we_o && cache_rreq_o) both_cnt++;
    if (inst_valid_o && inst_ready_i && !redirect_i && !rst) pop_pc_q.push_back(inst_pc_o);
    @(posedge clk);
    #1;
    cache_hit_i  = rq && hit_en;
    cache_inst_i = rq ? cache_of(ra) : 32'h0;
    mem_byte_i   = acc ? mem_of(ma) : 8'hEE;
    #1;
  endtask

  task automatic wait_valid(input int max, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (inst_valid_o) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_acc(input int target, input int max);
    for (int i = 0; i < max && acc_cnt < target; i++) tick();
    chk("acc_reached", 32'(acc_cnt), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_i = 1'b0; mem_gnt_i = 1'b1; inst_ready_i = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(inst_valid_o), 0);
    chk("rst_rreq", 32'(cache_rreq_o), 0);
    chk("rst_mreq", 32'(mem_req_o), 0);
    chk("rst_we", 32'(cache_we_o), 0);
    rreq_cnt = 0; we_cnt = 0; mreq_cnt = 0; acc_cnt = 0;
    pop_pc_q.delete();
    rst = 1'b0;
  endtask

  task automatic start_at(input logic [31:0] pc);
    redirect_i = 1'b1; redirect_addr_i = pc;
    tick();
    redirect_i = 1'b0;
  endtask

  initial begin
    both_cnt = 0;

    // Hit stream from reset with decode always ready.
    hit_en = 1'b1;
    do_reset();
    inst_ready_i = 1'b1;
    tick(); chk("hit_lat1", 32'(inst_valid_o), 0);
    tick(); chk("hit_lat2", 32'(inst_valid_o), 0);
    tick(); chk("hit_lat3", 32'(inst_valid_o), 1);
    chk("hit_pc0", inst_pc_o, 32'h0);
    chk("hit_inst0", inst_o, 32'hA000_0000);
    repeat (10) tick();
    chk("hit_npop", 32'(pop_pc_q.size() >= 3), 1);
    chk("hit_pop0", pop_pc_q[0], 32'h0);
    chk("hit_pop1", pop_pc_q[1], 32'h4);
    chk("hit_pop2", pop_pc_q[2], 32'h8);
    chk("hit_no_mreq", 32'(mreq_cnt), 0);

    // Miss and refill at 0x10 with continuous grant.
    hit_en = 1'b0;
    do_reset();
    start_at(32'h10);
    wait_valid(30, n);
    chk("miss_lat", 32'(n), 8);
    chk("miss_inst", inst_o, 32'h0010_0513);
    chk("miss_pc", inst_pc_o, 32'h10);
    chk("miss_we_cnt", 32'(we_cnt), 1);
    chk("miss_we_addr", last_we_addr, 32'h10);
    chk("miss_we_data", last_we_data, 32'h0010_0513);

    // Arbiter stall after the second accepted byte.
    do_reset();
    start_at(32'h10);
    wait_acc(2, 20);
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 32'(mem_req_o), 1);
      chk("stall_addr", mem_addr_o, 32'h12);
      tick();
    end
    mem_gnt_i = 1'b1;
    wait_valid(30, n);
    chk("stall_valid", 32'(inst_valid_o), 1);
    chk("stall_inst", inst_o, 32'h0010_0513);
    chk("stall_pc", inst_pc_o, 32'h10);
    chk("stall_acc", 32'(acc_cnt), 4);
    chk("stall_we_cnt", 32'(we_cnt), 1);

    // Queue fills with decode stalled, then one pop admits one lookup.
    hit_en = 1'b1;
    do_reset();
    repeat (20) tick();
    chk("full_rreq", 32'(rreq_cnt), 4);
    chk("full_head", inst_pc_o, 32'h0);
    repeat (5) tick();
    chk("full_parked", 32'(rreq_cnt), 4);
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    repeat (6) tick();
    chk("full_one_more", 32'(rreq_cnt), 5);
    chk("full_head2", inst_pc_o, 32'h4);
    inst_ready_i = 1'b1;
    repeat (4) tick();
    inst_ready_i = 1'b0;
    chk("full_drain_n", 32'(pop_pc_q.size()), 5);
    chk("full_drain1", pop_pc_q[1], 32'h4);
    chk("full_drain4", pop_pc_q[4], 32'h10);

    // Redirect to 0x100 while the old refill has two bytes accepted.
    hit_en = 1'b0;
    do_reset();
    start_at(32'h10);
    wait_acc(2, 20);
    chk("redir_mreq_before", 32'(mem_req_o), 1);
    redirect_i = 1'b1; redirect_addr_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    hit_en = 1'b1;
    chk("redir_rreq", 32'(cache_rreq_o), 1);
    chk("redir_raddr", cache_raddr_o, 32'h100);
    chk("redir_mreq_drop", 32'(mem_req_o), 0);
    chk("redir_empty", 32'(inst_valid_o), 0);
    wait_valid(10, n);
    chk("redir_lat", 32'(n), 2);
    chk("redir_pc", inst_pc_o, 32'h100);
    chk("redir_inst", inst_o, 32'hA000_0100);
    chk("redir_no_we", 32'(we_cnt), 0);

    // Redirect and pop together against a full queue.
    do_reset();
    repeat (20) tick();
    chk("rp_full", 32'(inst_valid_o), 1);
    inst_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_addr_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    inst_ready_i = 1'b0;
    chk("rp_flushed", 32'(inst_valid_o), 0);
    chk("rp_no_pop", 32'(pop_pc_q.size()), 0);
    wait_valid(10, n);
    chk("rp_first_pc", inst_pc_o, 32'h200);
    inst_ready_i = 1'b1;
    repeat (4) tick();
    inst_ready_i = 1'b0;
    chk("rp_pop0", pop_pc_q[0], 32'h200);
    chk("rp_pop1", pop_pc_q[1], 32'h204);

    chk("we_rreq_overlap", 32'(both_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
